// File: rtl/multiport_register_file_pkg.sv
// rtl/multiport_register_file_pkg.sv - shared sizes and sweep FSM encodings for the register file
// Default widths for multiport_register_file and its scoreboard.
package multiport_register_file_pkg;

  localparam int DATA_LEN     = 32;
  localparam int REG_NUM      = 32;
  localparam int REG_ADDR_LEN = $clog2(REG_NUM);

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// rtl/multiport_register_file_scoreboard.sv - per-register busy bits with set-over-clear priority
// Module regfile_scoreboard: register 0 is never busy.
module regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_REGS-1:0]      clr_mask,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rbusy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // A new producer supersedes a completing one, so the set is applied after the clears.
  always_comb begin
    busy_d = busy_q & ~clr_mask;
    if (set_en) begin
      busy_d[set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rbusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rbusy[k] = busy_q[raddr[k*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// rtl/multiport_register_file.sv - multi-read, dual-write register file with busy scoreboard and clear sweep
// Optional same-cycle write-to-read forwarding under REGFILE_BYPASS_EN.
module multiport_register_file
  import multiport_register_file_pkg::*;
#(
  parameter int DATA_W   = DATA_LEN,
  parameter int NUM_REGS = REG_NUM,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic [DATA_W-1:0]        wdata0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic [DATA_W-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     clr_req,
  output logic                     ready
);

  rf_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic                w0_acc, w1_acc, set_en, sweeping;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_RD-1:0]   sb_rbusy;

  assign ready    = (state_q == RF_IDLE);
  assign sweeping = (state_q == RF_SWEEP);
  assign w0_acc   = we0 && ready && (waddr0 != '0);
  assign w1_acc   = we1 && ready && (waddr1 != '0);
  assign set_en   = issue_valid && ready && (issue_addr != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_SWEEP;
          cnt_d   = ADDR_W'(1);
        end
      end
      RF_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d = RF_IDLE;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    if (w0_acc) begin
      regs_d[waddr0] = wdata0;
    end
    if (w1_acc) begin
      regs_d[waddr1] = wdata1;
    end
    if (sweeping) begin
      regs_d[cnt_q] = '0;
    end
    regs_d[0] = '0;
  end

  always_comb begin
    clr_mask = '0;
    if (w0_acc) begin
      clr_mask[waddr0] = 1'b1;
    end
    if (w1_acc) begin
      clr_mask[waddr1] = 1'b1;
    end
    if (sweeping) begin
      clr_mask[cnt_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_addr (issue_addr),
    .clr_mask (clr_mask),
    .raddr    (raddr),
    .rbusy    (sb_rbusy)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rdata[k*DATA_W +: DATA_W] = (ra == '0) ? '0 : regs_q[ra];
      rbusy[k]                  = sb_rbusy[k];
`ifdef REGFILE_BYPASS_EN
      if (ra != '0) begin
        if (w1_acc && (waddr1 == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wdata1;
          rbusy[k]                  = set_en && (issue_addr == ra);
        end else if (w0_acc && (waddr0 == ra)) begin
          rdata[k*DATA_W +: DATA_W] = wdata0;
          rbusy[k]                  = set_en && (issue_addr == ra);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// tb/tb_multiport_register_file.sv - table-driven, scoreboarded bench for multiport_register_file
module tb_multiport_register_file;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int RD = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]   waddr0 = '0, waddr1 = '0;
  logic [DW-1:0]   wdata0 = '0, wdata1 = '0;
  logic [AW-1:0]   ra0 = '0, ra1 = '0;
  logic [RD*AW-1:0] raddr;
  logic [RD*DW-1:0] rdata;
  logic [RD-1:0]   rbusy;
  logic            issue_valid = 1'b0;
  logic [AW-1:0]   issue_addr = '0;
  logic            clr_req = 1'b0;
  logic            ready;

  assign raddr = {ra1, ra0};

  always #5 clk = ~clk;

  multiport_register_file dut (
    .clk         (clk),
    .rst         (rst),
    .we0         (we0),
    .waddr0      (waddr0),
    .wdata0      (wdata0),
    .we1         (we1),
    .waddr1      (waddr1),
    .wdata1      (wdata1),
    .raddr       (raddr),
    .rdata       (rdata),
    .rbusy       (rbusy),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .clr_req     (clr_req),
    .ready       (ready)
  );

  typedef struct {
    logic          we0;
    logic [AW-1:0] waddr0;
    logic [DW-1:0] wdata0;
    logic          we1;
    logic [AW-1:0] waddr1;
    logic [DW-1:0] wdata1;
    logic          iv;
    logic [AW-1:0] ia;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [DW-1:0] exp_d0;
    logic [DW-1:0] exp_d1;
    logic [1:0]    exp_b;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    b;
  } exp_t;

  vec_t vecs [9];
  exp_t sb_q [$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    we0 = v.we0; waddr0 = v.waddr0; wdata0 = v.wdata0;
    we1 = v.we1; waddr1 = v.waddr1; wdata1 = v.wdata1;
    issue_valid = v.iv; issue_addr = v.ia;
    ra0 = v.ra0; ra1 = v.ra1;
    sb_q.push_back('{d0: v.exp_d0, d1: v.exp_d1, b: v.exp_b});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check($sformatf("vec%0d_rdata", idx), {32'h0, rdata[DW-1:0]}, {32'h0, e.d0});
    check($sformatf("vec%0d_rdata1", idx), {32'h0, rdata[2*DW-1:DW]}, {32'h0, e.d1});
    check($sformatf("vec%0d_rbusy", idx), {62'h0, rbusy}, {62'h0, e.b});
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; we1 = 1'b0; issue_valid = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    int lowcnt;

    //           we0 wa0 wd0           we1 wa1 wd1           iv ia  r0  r1  d0            d1            busy
    vecs[0] = '{1'b1, 5, 32'hDEADBEEF, 1'b1, 5, 32'h12345678, 1'b0, 0,  5,  5, 32'h12345678, 32'h12345678, 2'b00};
    vecs[1] = '{1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 32'h0,        1'b1, 0,  0,  5, 32'h0,        32'h12345678, 2'b00};
    vecs[2] = '{1'b0, 0, 32'h0,        1'b0, 0, 32'h0,        1'b1, 7,  7,  0, 32'h0,        32'h0,        2'b01};
    vecs[3] = '{1'b1, 7, 32'h00000077, 1'b0, 0, 32'h0,        1'b1, 7,  7,  5, 32'h00000077, 32'h12345678, 2'b01};
    vecs[4] = '{1'b0, 0, 32'h0,        1'b1, 7, 32'h00000088, 1'b0, 0,  7,  7, 32'h00000088, 32'h00000088, 2'b00};
    vecs[5] = '{1'b1,10, 32'hAAAA0000, 1'b1,11, 32'hBBBB1111, 1'b0, 0, 10, 11, 32'hAAAA0000, 32'hBBBB1111, 2'b00};
    vecs[6] = '{1'b1, 3, 32'h33333333, 1'b0, 0, 32'h0,        1'b1,12, 12,  3, 32'h0,        32'h33333333, 2'b01};
    vecs[7] = '{1'b1,12, 32'h00C0FFEE, 1'b0, 0, 32'h0,        1'b0, 0, 12,  3, 32'h00C0FFEE, 32'h33333333, 2'b00};
    vecs[8] = '{1'b1,31, 32'hFFFFFFFF, 1'b1, 1, 32'h00000001, 1'b0, 0, 31,  1, 32'hFFFFFFFF, 32'h00000001, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {63'h0, ready}, 64'h1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ra0 = AW'(i); ra1 = AW'(NR - 1 - i);
      #1;
      check($sformatf("rst_read%0d", i), {rdata, 30'h0, rbusy}, 64'h0);
    end

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i], i);
    end
    @(negedge clk);
    idle_inputs();
    check("ready_idle", {63'h0, ready}, 64'h1);

    // same-cycle visibility of a write to the port being read
    @(negedge clk);
    we0 = 1'b1; waddr0 = 9; wdata0 = 32'hA5A5A5A5; ra0 = 9;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("fwd_same_cycle", {32'h0, rdata[DW-1:0]}, {32'h0, 32'hA5A5A5A5});
`else
    check("nofwd_same_cycle", {32'h0, rdata[DW-1:0]}, 64'h0);
`endif
    @(posedge clk);
    #1;
    check("fwd_next_cycle", {32'h0, rdata[DW-1:0]}, {32'h0, 32'hA5A5A5A5});

    for (int i = 1; i < NR; i++) begin
      @(negedge clk);
      we0 = 1'b1; waddr0 = AW'(i); wdata0 = DW'(i);
    end
    @(negedge clk);
    we0 = 1'b0; ra0 = 17; ra1 = 31;
    #1;
    check("fill_r17", {32'h0, rdata[DW-1:0]}, 64'd17);
    check("fill_r31", {32'h0, rdata[2*DW-1:DW]}, 64'd31);

    clr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    we0 = 1'b1; waddr0 = 3; wdata0 = 32'h00000BAD;
    issue_valid = 1'b1; issue_addr = 7;
    lowcnt = 0;
    while (!ready && lowcnt < 100) begin
      lowcnt++;
      @(negedge clk);
    end
    idle_inputs();
    check("sweep_ready_low_cycles", 64'(lowcnt), 64'd31);
    for (int i = 0; i < NR; i++) begin
      ra0 = AW'(i); ra1 = AW'(i);
      #1;
      check($sformatf("swept_read%0d", i), {rdata[DW-1:0], 30'h0, rbusy}, 64'h0);
    end

    // second sweep aborted by reset partway through
    @(negedge clk);
    we0 = 1'b1; waddr0 = 25; wdata0 = 32'h00000025;
    @(negedge clk);
    we0 = 1'b1; waddr0 = 4; wdata0 = 32'h00000044;
    @(negedge clk);
    we0 = 1'b0;
    clr_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_req = 1'b0;
    repeat (9) @(negedge clk);
    ra0 = 25; ra1 = 4;
    #1;
    check("midsweep_ready", {63'h0, ready}, 64'h0);
    check("midsweep_live_reads", rdata, {32'h0, 32'h00000025});
    rst = 1'b1;
    #1;
    check("abort_ready", {63'h0, ready}, 64'h1);
    check("abort_r25", {32'h0, rdata[DW-1:0]}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    we1 = 1'b1; waddr1 = 2; wdata1 = 32'h0BADCAFE; ra0 = 2;
    @(posedge clk);
    #1;
    check("post_abort_write", {32'h0, rdata[DW-1:0]}, {32'h0, 32'h0BADCAFE});
    check("post_abort_ready", {63'h0, ready}, 64'h1);
    @(negedge clk);
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
